// File: rtl/dm_access_unit_if.sv
// CPU-side and RAM-side signals of the data-memory access unit, bundled so the
// unit and its environment connect through a single port.
interface dm_access_unit_if;
    // RAM handshake: ram_req rises with a latched request and stays high, with
    // ram_we/ram_addr/ram_be/ram_wdata frozen, until the single-cycle ram_ack;
    // the RAM returns exactly one ack per request.
    logic        mem_r;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic        stall;
    logic        misalign;
    logic        ram_req;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport master (
        output mem_r, mem_w, Addr_in, Data_in, DMType, ram_rdata, ram_ack,
        input  Data_out, stall, misalign, ram_req, ram_we, ram_addr, ram_be, ram_wdata
    );

    modport slave (
        input  mem_r, mem_w, Addr_in, Data_in, DMType, ram_rdata, ram_ack,
        output Data_out, stall, misalign, ram_req, ram_we, ram_addr, ram_be, ram_wdata
    );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns MEM-stage loads/stores into word-addressed RAM
// requests with byte lanes, stalls the CPU until done, and extends load data.
module dm_access_unit (
    input  logic                    clk,
    input  logic                    reset,
    dm_access_unit_if.slave         bus,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  type_q, type_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;

    logic        cpu_req;
    logic        aligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_val;

    assign cpu_req = bus.mem_r | bus.mem_w;

    // Alignment, lane enables and lane-replicated store data for the incoming request
    always_comb begin
        aligned  = (bus.Addr_in[1:0] == 2'b00);
        be_in    = 4'b1111;
        wdata_in = bus.Data_in;
        case (bus.DMType)
            3'b001, 3'b010: begin
                aligned  = ~bus.Addr_in[0];
                be_in    = bus.Addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{bus.Data_in[15:0]}};
            end
            3'b011, 3'b100: begin
                aligned  = 1'b1;
                be_in    = 4'b0001 << bus.Addr_in[1:0];
                wdata_in = {4{bus.Data_in[7:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the latched address bits, not the live CPU inputs
    always_comb begin
        half_sel = lo_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        case (lo_q)
            2'd0:    byte_sel = bus.ram_rdata[7:0];
            2'd1:    byte_sel = bus.ram_rdata[15:8];
            2'd2:    byte_sel = bus.ram_rdata[23:16];
            default: byte_sel = bus.ram_rdata[31:24];
        endcase
        case (type_q)
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = {16'h0000, half_sel};
            3'b011:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'h000000, byte_sel};
            default: load_val = bus.ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        type_d  = type_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req && aligned) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    we_d    = bus.mem_w;
                    addr_d  = bus.Addr_in[31:2];
                    lo_d    = bus.Addr_in[1:0];
                    type_d  = bus.DMType;
                    be_d    = be_in;
                    wdata_d = wdata_in;
                end
            end
            S_BUSY: begin
                if (bus.ram_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) data_d = load_val;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 30'd0;
            lo_q    <= 2'd0;
            type_q  <= 3'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            type_q  <= type_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // The stall drops in DONE so the frozen pipeline advances exactly once
    assign bus.stall     = cpu_req & aligned & (state_q != S_DONE);
    assign bus.misalign  = cpu_req & ~aligned;
    assign bus.ram_req   = req_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_be    = be_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.Data_out  = data_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: loads, stores, lane placement, misalignment,
// stray acks and reset during an access.
module tb_dm_access_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;

    dm_access_unit_if bus();

    dm_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request, answers it after ack_k cycles of ram_req, and reports
    // what was observed; inputs change only just after negedge.
    task automatic run_access(
        input  logic        r, w,
        input  logic [31:0] addr, data,
        input  logic [2:0]  ty,
        input  int          ack_k,
        input  logic [31:0] rdata,
        output int          stall_cnt,
        output logic        seen_we,
        output logic [29:0] seen_addr,
        output logic [3:0]  seen_be,
        output logic [31:0] seen_wdata,
        output logic        unstable,
        output logic        done_stall,
        output logic        done_req,
        output logic [1:0]  done_state,
        output logic [31:0] done_data,
        output logic        timeout
    );
        stall_cnt = 0;
        unstable  = 1'b0;
        timeout   = 1'b1;
        @(negedge clk);
        bus.mem_r = r; bus.mem_w = w; bus.Addr_in = addr;
        bus.Data_in = data; bus.DMType = ty; bus.ram_ack = 1'b0;
        #1;
        if (bus.stall) stall_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.stall) stall_cnt++;
            if (bus.ram_req) begin
                timeout = 1'b0;
                break;
            end
        end
        seen_we = bus.ram_we; seen_addr = bus.ram_addr;
        seen_be = bus.ram_be; seen_wdata = bus.ram_wdata;
        if (!timeout) begin
            for (int i = 1; i < ack_k; i++) begin
                @(negedge clk); #1;
                if (bus.stall) stall_cnt++;
                if (!bus.ram_req || bus.ram_we !== seen_we || bus.ram_addr !== seen_addr ||
                    bus.ram_be !== seen_be || bus.ram_wdata !== seen_wdata) unstable = 1'b1;
            end
            bus.ram_ack = 1'b1;
            bus.ram_rdata = rdata;
            @(negedge clk);
            bus.ram_ack = 1'b0;
            #1;
        end
        done_stall = bus.stall; done_req = bus.ram_req;
        done_state = dbg_state; done_data = bus.Data_out;
        @(negedge clk);
        bus.mem_r = 1'b0; bus.mem_w = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.Addr_in = 32'd0; bus.Data_in = 32'd0;
        bus.DMType = 3'd0; bus.ram_rdata = 32'd0; bus.ram_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        checks++; if (bus.ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b want 0", bus.ram_req); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
        checks++; if (bus.ram_be !== 4'h0) begin errors++; $display("FAIL reset_ram_be: got %h want 0", bus.ram_be); end
        checks++; if (bus.ram_addr !== 30'h0) begin errors++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr); end
        checks++; if (bus.ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_wdata: got %h want 0", bus.ram_wdata); end
        checks++; if (bus.Data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", bus.Data_out); end
        checks++; if (bus.stall !== 1'b0 || bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_stall_misalign: got %b%b want 00", bus.stall, bus.misalign); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw_slow;
        int s; logic we, un, ds, dr, to; logic [29:0] a; logic [3:0] be; logic [31:0] wd, dd; logic [1:0] st;
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b000, 3, 32'h8081_8283, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL lw_req_timeout: got %b want 0", to); end
        checks++; if (a !== 30'h40) begin errors++; $display("FAIL lw_ram_addr: got %h want 40", a); end
        checks++; if (be !== 4'hF || we !== 1'b0) begin errors++; $display("FAIL lw_be_we: got %h/%b want f/0", be, we); end
        checks++; if (s != 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 4", s); end
        checks++; if (un !== 1'b0) begin errors++; $display("FAIL lw_bus_stable: got %b want 0", un); end
        checks++; if (st !== 2'd2 || ds !== 1'b0 || dr !== 1'b0) begin errors++; $display("FAIL lw_done: got st=%0d stall=%b req=%b want 2/0/0", st, ds, dr); end
        checks++; if (dd !== 32'h8081_8283) begin errors++; $display("FAIL lw_data: got %h want 80818283", dd); end
    endtask

    task automatic test_lb_lbu;
        int s; logic we, un, ds, dr, to; logic [29:0] a; logic [3:0] be; logic [31:0] wd, dd; logic [1:0] st;
        run_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b011, 1, 32'h8081_8283, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (s != 2) begin errors++; $display("FAIL lb_min_latency_stall: got %0d want 2", s); end
        checks++; if (be !== 4'h8) begin errors++; $display("FAIL lb_be: got %h want 8", be); end
        checks++; if (dd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", dd); end
        run_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 1, 32'h8081_8283, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (dd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", dd); end
    endtask

    task automatic test_half_loads;
        int s; logic we, un, ds, dr, to; logic [29:0] a; logic [3:0] be; logic [31:0] wd, dd; logic [1:0] st;
        run_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 2, 32'h8001_1234, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (dd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", dd); end
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 1, 32'h8001_1234, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (dd !== 32'h0000_1234 || be !== 4'h3) begin errors++; $display("FAIL lhu_data_be: got %h/%h want 00001234/3", dd, be); end
    endtask

    task automatic test_sh;
        int s; logic we, un, ds, dr, to; logic [29:0] a; logic [3:0] be; logic [31:0] wd, dd; logic [1:0] st;
        run_access(1'b0, 1'b1, 32'h102, 32'h0000_BEEF, 3'b001, 2, 32'h0, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (we !== 1'b1 || be !== 4'hC || a !== 30'h40) begin errors++; $display("FAIL sh_we_be_addr: got %b/%h/%h want 1/c/40", we, be, a); end
        checks++; if (wd !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", wd); end
        checks++; if (ds !== 1'b0 || st !== 2'd2 || dr !== 1'b0) begin errors++; $display("FAIL sh_done: got stall=%b st=%0d req=%b want 0/2/0", ds, st, dr); end
        checks++; if (dd !== 32'h0000_1234) begin errors++; $display("FAIL sh_data_hold: got %h want 00001234", dd); end
        checks++; if (bus.ram_req !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL sh_single_ack: got req=%b st=%0d want 0/0", bus.ram_req, dbg_state); end
    endtask

    task automatic test_sb;
        int s; logic we, un, ds, dr, to; logic [29:0] a; logic [3:0] be; logic [31:0] wd, dd; logic [1:0] st;
        run_access(1'b0, 1'b1, 32'h101, 32'h0000_00A5, 3'b011, 1, 32'h0, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (be !== 4'h2 || wd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_lanes: got %h/%h want 2/a5a5a5a5", be, wd); end
    endtask

    task automatic test_rw_both;
        int s; logic we, un, ds, dr, to; logic [29:0] a; logic [3:0] be; logic [31:0] wd, dd; logic [1:0] st;
        run_access(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 3'b000, 1, 32'h1111_1111, s, we, a, be, wd, un, ds, dr, st, dd, to);
        checks++; if (we !== 1'b1 || a !== 30'h80 || be !== 4'hF || wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_store: got %b/%h/%h/%h want 1/80/f/deadbeef", we, a, be, wd); end
        checks++; if (dd !== 32'h0000_1234) begin errors++; $display("FAIL rw_data_hold: got %h want 00001234", dd); end
    endtask

    task automatic test_misalign;
        logic [31:0] addrs[3] = '{32'h101, 32'h203, 32'h102};
        logic [2:0]  tys[3]   = '{3'b000, 3'b001, 3'b111};
        logic        wr[3]    = '{1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            bus.mem_r = ~wr[v]; bus.mem_w = wr[v]; bus.Addr_in = addrs[v];
            bus.DMType = tys[v]; bus.Data_in = 32'h1234_5678;
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++;
                if (bus.misalign !== 1'b1 || bus.stall !== 1'b0 || bus.ram_req !== 1'b0 || dbg_state !== 2'd0) begin
                    errors++;
                    $display("FAIL misalign_%0d_c%0d: got mis=%b stall=%b req=%b st=%0d want 1/0/0/0",
                             v, c, bus.misalign, bus.stall, bus.ram_req, dbg_state);
                end
                @(negedge clk);
            end
            bus.mem_r = 1'b0; bus.mem_w = 1'b0;
        end
    endtask

    task automatic test_ack_idle;
        @(negedge clk);
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.ram_ack = 1'b0;
        #1;
        checks++;
        if (dbg_state !== 2'd0 || bus.ram_req !== 1'b0 || bus.Data_out !== 32'h0000_1234) begin
            errors++;
            $display("FAIL ack_idle: got st=%0d req=%b data=%h want 0/0/00001234", dbg_state, bus.ram_req, bus.Data_out);
        end
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        bus.mem_r = 1'b1; bus.Addr_in = 32'h100; bus.DMType = 3'b000;
        @(negedge clk); #1;
        checks++; if (bus.ram_req !== 1'b1 || dbg_state !== 2'd1) begin errors++; $display("FAIL rb_busy: got req=%b st=%0d want 1/1", bus.ram_req, dbg_state); end
        @(negedge clk);
        reset = 1'b1; bus.mem_r = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dbg_state !== 2'd0 || bus.ram_req !== 1'b0 || bus.stall !== 1'b0 || bus.Data_out !== 32'h0) begin
            errors++;
            $display("FAIL rb_after_reset: got st=%0d req=%b stall=%b data=%h want 0/0/0/0", dbg_state, bus.ram_req, bus.stall, bus.Data_out);
        end
        @(negedge clk);
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h8081_8283;
        @(negedge clk);
        bus.ram_ack = 1'b0;
        #1;
        checks++;
        if (dbg_state !== 2'd0 || bus.ram_req !== 1'b0 || bus.Data_out !== 32'h0) begin
            errors++;
            $display("FAIL rb_late_ack: got st=%0d req=%b data=%h want 0/0/0", dbg_state, bus.ram_req, bus.Data_out);
        end
    endtask

    initial begin
        test_reset();
        test_lw_slow();
        test_lb_lbu();
        test_half_loads();
        test_sh();
        test_sb();
        test_rw_both();
        test_misalign();
        test_ack_idle();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
